ef_i2s_tx: RTL and testbench



---
 rtl/ef_i2s_pkg.sv | 21 ++
 rtl/ef_i2s_tx_if.sv | 8 +
 rtl/ef_i2s_clkgen.sv | 39 +++
 rtl/ef_i2s_tx.sv | 95 +++++++++
 tb/tb_ef_i2s_tx.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ef_i2s_pkg.sv
// ef_i2s_pkg: shared state type, slot constants and sample alignment for the EF I2S blocks.
package ef_i2s_pkg;

    typedef enum logic [1:0] {IDLE, START, RUN} state_t;

    localparam int SLOT_BITS = 32;
    localparam int CH_LEFT   = 1;
    localparam int CH_RIGHT  = 0;
    localparam logic [4:0] LOAD_SLOT_I2S = 5'd1;
    localparam logic [4:0] LOAD_SLOT_LJ  = 5'd0;

    // Keep the low n bits of a right-aligned sample and move them to the MSB end.
    function automatic logic [SLOT_BITS-1:0] msb_align(logic [31:0] d, logic [5:0] n);
        logic [5:0]  k;
        logic [63:0] m;
        k = (n > 6'd32) ? 6'd32 : n;
        m = ({32'd0, d} & ((64'd1 << k) - 64'd1)) << (7'd32 - {1'b0, k});
        return m[SLOT_BITS-1:0];
    endfunction

endpackage

// File: rtl/ef_i2s_tx_if.sv
// ef_i2s_tx_if: valid/ready sample stream feeding the I2S transmitter.
interface ef_i2s_tx_if #(parameter int DW = 32);
    logic [DW-1:0] tx_data;
    logic          tx_valid;
    logic          tx_ready;
    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/ef_i2s_clkgen.sv
// ef_i2s_clkgen: SCK/WS generator with bit counter and SCK falling-edge strobe.
module ef_i2s_clkgen
    import ef_i2s_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    input  logic [7:0] sck_prescaler,
    output logic       sck,
    output logic       ws,
    output logic       fall,
    output logic [4:0] bit_ctr
);

    logic [7:0] presc;
    logic       tick;

    assign tick = run & (presc == 8'd0);
    assign fall = tick & sck;

    always_ff @(posedge clk) begin
        if (!rst_n || !run) begin
            presc   <= 8'd0;
            sck     <= 1'b0;
            ws      <= 1'b1;
            bit_ctr <= 5'd0;
        end else begin
            presc <= (presc == 8'd0) ? sck_prescaler : presc - 8'd1;
            if (tick)
                sck <= ~sck;
            if (fall) begin
                bit_ctr <= bit_ctr + 5'd1;
                if (bit_ctr == 5'(SLOT_BITS - 1))
                    ws <= ~ws;
            end
        end
    end

endmodule

// File: rtl/ef_i2s_tx.sv
// ef_i2s_tx: I2S/left-justified master transmitter with channel masking and sticky underrun.
// Optional I2S_TX_MONO_EN adds a mono port that replays the left word in the right slot.
module ef_i2s_tx
    import ef_i2s_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [7:0] sck_prescaler,
    input  logic       left_justified,
    input  logic [5:0] sample_size,
    input  logic [1:0] channels,
`ifdef I2S_TX_MONO_EN
    input  logic       mono,
`endif
    ef_i2s_tx_if.slave tx,
    input  logic       underrun_clr,
    output logic       underrun,
    output logic       sck,
    output logic       ws,
    output logic       sdo
);

    state_t      state, state_nx;
    logic        run, fall, slot_end, ws_nx, load, clr0, ch_en, replay, have, ready;
    logic [4:0]  bit_ctr, bit_nx;
    logic [DW-1:0] data;
    logic [31:0] d32, src, sr, load_val;
`ifdef I2S_TX_MONO_EN
    logic [31:0] hold;
`endif

    assign data        = tx.tx_data;
    assign d32         = 32'(data);
    assign run         = en & (state != IDLE);
    assign tx.tx_ready = ready;
    assign sdo         = sr[31];

    ef_i2s_clkgen u_clkgen (
        .clk           (clk),
        .rst_n         (rst_n),
        .run           (run),
        .sck_prescaler (sck_prescaler),
        .sck           (sck),
        .ws            (ws),
        .fall          (fall),
        .bit_ctr       (bit_ctr)
    );

    always_ff @(posedge clk)
        state <= !rst_n ? IDLE : state_nx;

    // ws_nx names the slot being loaded: in left-justified mode the load shares the ws toggle fall.
    always_comb begin
        slot_end = fall & (bit_ctr == 5'(SLOT_BITS - 1));
        state_nx = !en ? IDLE : (state == IDLE) ? START : (state == START && slot_end) ? RUN : state;
        bit_nx   = bit_ctr + 5'd1;
        ws_nx    = ws ^ slot_end;
        load     = fall & (bit_nx == (left_justified ? LOAD_SLOT_LJ : LOAD_SLOT_I2S));
        clr0     = fall & ~left_justified & (bit_nx == 5'd0);
        ch_en    = ws_nx ? channels[CH_RIGHT] : channels[CH_LEFT];
`ifdef I2S_TX_MONO_EN
        replay   = mono & ws_nx;
        src      = replay ? hold : d32;
`else
        replay   = 1'b0;
        src      = d32;
`endif
        have     = replay | tx.tx_valid;
        ready    = (state == RUN) & load & ch_en & ~replay;
        load_val = ((state == RUN) & ch_en & have) ? msb_align(src, sample_size) : 32'd0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n || !run) begin
            sr       <= 32'd0;
            underrun <= 1'b0;
        end else begin
            sr       <= load ? load_val : clr0 ? 32'd0 : fall ? {sr[30:0], 1'b0} : sr;
            underrun <= underrun_clr ? 1'b0 : underrun | (ready & ~tx.tx_valid);
        end
    end

`ifdef I2S_TX_MONO_EN
    always_ff @(posedge clk) begin
        if (!rst_n)
            hold <= 32'd0;
        else if (ready & ~ws_nx)
            hold <= tx.tx_valid ? d32 : 32'd0;
    end
`endif

endmodule

// File: tb/tb_ef_i2s_tx.sv
// tb_ef_i2s_tx: self-checking bench for ef_i2s_tx using a slot-level reference model.
module tb_ef_i2s_tx;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       left_justified = 1'b0;
    logic       underrun_clr = 1'b0;
    logic [7:0] sck_prescaler = 8'd0;
    logic [5:0] sample_size = 6'd0;
    logic [1:0] channels = 2'b00;
    logic       underrun, sck, ws, sdo;
`ifdef I2S_TX_MONO_EN
    logic       mono = 1'b0;
`endif

    ef_i2s_tx_if #(.DW(32)) tx_if ();

    ef_i2s_tx #(.DW(32)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .en             (en),
        .sck_prescaler  (sck_prescaler),
        .left_justified (left_justified),
        .sample_size    (sample_size),
        .channels       (channels),
`ifdef I2S_TX_MONO_EN
        .mono           (mono),
`endif
        .tx             (tx_if.slave),
        .underrun_clr   (underrun_clr),
        .underrun       (underrun),
        .sck            (sck),
        .ws             (ws),
        .sdo            (sdo)
    );

    always #5 clk = ~clk;

    typedef struct {logic [31:0] w; int pops;} slot_t;
    typedef struct {bit lj; logic [5:0] sz; logic [1:0] ch; logic [31:0] w0, w1, e3, e4;} vec_t;

    int total = 0;
    int passed = 0;
    logic [31:0] src[8];
    int src_n = 1;
    int pops = 0;
    bit pend = 1'b0;
    bit src_rst = 1'b1;
    slot_t slots[$];
    slot_t got[$];
    int cap_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: actual %0h required %0h", name, act, exp);
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [4:0] outs();
        return {sck, ws, sdo, tx_if.tx_ready, underrun};
    endfunction

    // Sample bits land MSB-first in the slot: bit k-1 of the sample is the first bit sent.
    function automatic logic [31:0] ref_align(logic [31:0] d, int k);
        logic [31:0] r = 32'd0;
        for (int i = 0; i < k && i < 32; i++) r[31-i] = d[k-1-i];
        return r;
    endfunction

    // Upstream FIFO: the head word advances one cycle after each accepted handshake.
    initial begin
        tx_if.tx_data = 32'd0;
        forever begin
            @(negedge clk);
            if (src_rst) pops = 0;
            else if (pend) pops++;
            tx_if.tx_data = src[pops % src_n];
            pend = !src_rst && tx_if.tx_valid && tx_if.tx_ready;
        end
    end

    // Receiver: samples sdo on every SCK rise and groups 32 bits per slot.
    initial begin
        logic [31:0] cur = 32'd0;
        bit sck_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (!en || !rst_n) begin
                cap_cnt = 0;
                cur = 32'd0;
                slots.delete();
            end else if (sck && !sck_prev) begin
                cur = {cur[30:0], sdo};
                cap_cnt++;
                if (cap_cnt == 32) begin
                    slots.push_back('{w: cur, pops: pops});
                    cap_cnt = 0;
                end
            end
            sck_prev = sck;
        end
    end

    task automatic run(input bit lj, input logic [5:0] sz, input logic [1:0] chn, input logic [7:0] p, input int n);
        en = 1'b0;
        src_rst = 1'b1;
        left_justified = lj;
        sample_size = sz;
        channels = chn;
        sck_prescaler = p;
        tx_if.tx_valid = 1'b1;
        cyc(3);
        src_rst = 1'b0;
        en = 1'b1;
        for (int t = 0; t < n * 70 * (int'(p) + 1) + 100 && slots.size() < n; t++) cyc(1);
        got = slots;
        en = 1'b0;
        chk("slots_captured", 64'(got.size()), 64'(n));
        cyc(2);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vec_t vt[8];
        int t, r1, r2, k;
        bit bad, prev_sck, lj;
        logic [5:0] sz;
        logic [1:0] chn;
        logic [7:0] p;
        logic [31:0] e;

        vt[0] = '{1'b1, 6'd16, 2'b11, 32'h3C3C, 32'hA5A5, 32'hA5A5_0000, 32'h3C3C_0000};
        vt[1] = '{1'b0, 6'd24, 2'b11, 32'h80_0001, 32'h12_3456, 32'h4000_0080, 32'h091A_2B00};
        vt[2] = '{1'b1, 6'd16, 2'b10, 32'hBEEF, 32'h1111, 32'hBEEF_0000, 32'h0};
        vt[3] = '{1'b1, 6'd0, 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0};
        vt[4] = '{1'b0, 6'd32, 2'b11, 32'hFFFF_FFFF, 32'h8000_0001, 32'h7FFF_FFFF, 32'h4000_0000};
        vt[5] = '{1'b1, 6'd32, 2'b11, 32'h1234_5678, 32'h9ABC_DEF0, 32'h9ABC_DEF0, 32'h1234_5678};
        vt[6] = '{1'b0, 6'd8, 2'b01, 32'hAB, 32'h5C, 32'h0, 32'h2E00_0000};
        vt[7] = '{1'b1, 6'd8, 2'b11, 32'hFFFF_FF81, 32'h42, 32'h4200_0000, 32'h8100_0000};

        tx_if.tx_valid = 1'b0;
        cyc(3);
        chk("reset_outputs", 64'(outs()), 64'(5'b01000));
        rst_n = 1'b1;
        cyc(2);
        chk("idle_outputs", 64'(outs()), 64'(5'b01000));

        for (int i = 0; i < 8; i++) begin
            src[0] = vt[i].w0;
            src[1] = vt[i].w1;
            src_n = 2;
            run(vt[i].lj, vt[i].sz, vt[i].ch, 8'd0, 5);
            chk($sformatf("vec%0d_start_slot", i), 64'(got[0].w), 64'd0);
            chk($sformatf("vec%0d_slot3", i), 64'(got[3].w), 64'(vt[i].e3));
            chk($sformatf("vec%0d_slot4", i), 64'(got[4].w), 64'(vt[i].e4));
        end

        // Timing with prescaler 1: SCK period, quiet START slot, first pop latency, frame period.
        src[0] = 32'hFFFF_FFFF;
        src_n = 1;
        left_justified = 1'b0;
        sample_size = 6'd32;
        channels = 2'b11;
        sck_prescaler = 8'd1;
        tx_if.tx_valid = 1'b1;
        src_rst = 1'b1;
        cyc(3);
        src_rst = 1'b0;
        en = 1'b1;
        t = 0; r1 = -1; r2 = -1; bad = 1'b0; prev_sck = 1'b0;
        while (ws !== 1'b0 && t < 400) begin
            cyc(1);
            t++;
            if (tx_if.tx_ready || sdo) bad = 1'b1;
            if (sck && !prev_sck) begin
                if (r1 < 0) r1 = t;
                else if (r2 < 0) r2 = t;
            end
            prev_sck = sck;
        end
        chk("first_ws_fall", 64'(ws), 64'd0);
        chk("sck_period", 64'(r2 - r1), 64'd4);
        chk("start_slot_quiet", 64'(bad), 64'd0);
        t = 0;
        while (!tx_if.tx_ready && t < 20) begin
            cyc(1);
            t++;
        end
        chk("first_pop_latency", 64'(t), 64'd3);
        while (ws !== 1'b1 && t < 600) begin cyc(1); t++; end
        while (ws !== 1'b0 && t < 600) begin cyc(1); t++; end
        chk("ws_period", 64'(t), 64'd256);
        rst_n = 1'b0;
        cyc(1);
        chk("reset_mid_run", 64'(outs()), 64'(5'b01000));
        rst_n = 1'b1;
        en = 1'b0;
        cyc(2);

        // Underrun: disabled slots stay silent, enabled starved slot sets the flag, clear wins.
        tx_if.tx_valid = 1'b0;
        left_justified = 1'b1;
        sample_size = 6'd16;
        channels = 2'b00;
        sck_prescaler = 8'd0;
        src_rst = 1'b1;
        cyc(3);
        src_rst = 1'b0;
        en = 1'b1;
        cyc(400);
        chk("no_underrun_disabled", 64'(underrun), 64'd0);
        chk("no_pop_disabled", 64'(pops), 64'd0);
        channels = 2'b10;
        t = 0;
        while (!underrun && t < 200) begin cyc(1); t++; end
        chk("underrun_set", 64'(underrun), 64'd1);
        underrun_clr = 1'b1;
        cyc(1);
        underrun_clr = 1'b0;
        chk("underrun_cleared", 64'(underrun), 64'd0);
        underrun_clr = 1'b1;
        cyc(300);
        chk("clear_priority", 64'(underrun), 64'd0);
        underrun_clr = 1'b0;
        en = 1'b0;
        cyc(2);

        // Drop enable mid-word, then re-enable and require a fresh START slot.
        src[0] = 32'hFFFF_FFFF;
        src_n = 1;
        channels = 2'b11;
        sample_size = 6'd32;
        tx_if.tx_valid = 1'b1;
        src_rst = 1'b1;
        cyc(3);
        src_rst = 1'b0;
        en = 1'b1;
        t = 0;
        while (!(slots.size() >= 3 && cap_cnt == 7) && t < 1000) begin cyc(1); t++; end
        chk("mid_word_sdo", 64'(sdo), 64'd1);
        en = 1'b0;
        cyc(1);
        chk("en_drop_outputs", 64'(outs()), 64'(5'b01000));
        run(1'b1, 6'd32, 2'b11, 8'd0, 2);
        chk("reenable_start_zero", 64'(got[0].w), 64'd0);
        chk("reenable_start_no_pop", 64'(got[0].pops), 64'd0);

        // Randomized configurations against the slot-level model.
        for (int it = 0; it < 4; it++) begin
            lj = 1'($urandom);
            sz = 6'($urandom_range(0, 32));
            chn = 2'($urandom);
            p = 8'($urandom_range(0, 2));
            src_n = 5;
            for (int j = 0; j < 5; j++) src[j] = $urandom;
            run(lj, sz, chn, p, 7);
            k = 0;
            for (int s = 0; s < 7; s++) begin
                if (s >= 1 && ((s % 2 == 0) ? chn[0] : chn[1]) && !(lj && s == 1)) begin
                    e = ref_align(src[k % src_n], int'(sz));
                    if (!lj) e = e >> 1;
                    k++;
                end else e = 32'd0;
                chk($sformatf("rand%0d_slot%0d", it, s), 64'(got[s].w), 64'(e));
            end
            chk($sformatf("rand%0d_pops", it), 64'(got[6].pops), 64'(k));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
